alu_cmd_sequencer: RTL and testbench

//  Upstream control stage for the 16-bit ALU execution units (arith, logic, compare, shift).

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_unit_decoder.sv | 18 +
 rtl/alu_cmd_sequencer.sv | 159 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared unit-select codes and sequencer FSM encodings for the ALU control path.
package alu_pkg;

    typedef enum logic [1:0] {
        ARITH = 2'b00,
        LOGIC = 2'b01,
        CMP   = 2'b10,
        SHIFT = 2'b11
    } unit_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    localparam int NUM_UNITS = 4;

endpackage

// File: rtl/alu_unit_decoder.sv
// Unit-select decoder: 2-bit sel gated by issue strobe -> one-hot enable; purely combinational.
// Bit order of enable: [0] arith, [1] logic, [2] cmp, [3] shift.
module alu_unit_decoder
    import alu_pkg::*;
(
    input  unit_sel_t                sel,
    input  logic                     issue,
    output logic [NUM_UNITS-1:0]     enable
);

    always_comb begin
        enable = '0;
        if (issue) begin
            enable[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: one command in, one-cycle unit enable, result/err out; nominal result 3 cycles after accept.
// Strictly one command in flight; cmd_ready low until the result is taken, result held stable under res_ready=0.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int IN_DATA_WIDTH  = 16,
    parameter int OUT_DATA_WIDTH = 16,
    parameter int TIMEOUT_CYC    = 8
)
(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [IN_DATA_WIDTH-1:0]  cmd_A,
    input  logic [IN_DATA_WIDTH-1:0]  cmd_B,
    input  logic [3:0]                cmd_func,
    output logic [IN_DATA_WIDTH-1:0]  A,
    output logic [IN_DATA_WIDTH-1:0]  B,
    output logic [1:0]                ALU_FUNC,
    output logic                      Arith_Enable,
    output logic                      Logic_Enable,
    output logic                      CMP_Enable,
    output logic                      Shift_Enable,
    input  logic [OUT_DATA_WIDTH-1:0] Arith_OUT,
    input  logic [OUT_DATA_WIDTH-1:0] Logic_OUT,
    input  logic [OUT_DATA_WIDTH-1:0] CMP_OUT,
    input  logic [OUT_DATA_WIDTH-1:0] Shift_OUT,
    input  logic                      Arith_Flag,
    input  logic                      Logic_Flag,
    input  logic                      CMP_Flag,
    input  logic                      Shift_Flag,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [OUT_DATA_WIDTH-1:0] res_data,
    output logic                      res_err
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    state_t                    state, state_nxt;
    unit_sel_t                 sel, sel_nxt;
    logic [NUM_UNITS-1:0]      en_q, en_nxt, dec_en;
    logic [CNT_W-1:0]          cnt, cnt_nxt, cnt_inc;
    logic [IN_DATA_WIDTH-1:0]  a_nxt, b_nxt;
    logic [1:0]                func_nxt;
    logic                      valid_nxt, err_nxt;
    logic [OUT_DATA_WIDTH-1:0] data_nxt, unit_res;
    logic [NUM_UNITS-1:0]      flags, sel_mask;
    logic                      accept;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable} = en_q;
    assign flags     = {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
    assign sel_mask  = 4'b0001 << sel;
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    alu_unit_decoder u_dec (
        .sel    (unit_sel_t'(cmd_func[3:2])),
        .issue  (accept),
        .enable (dec_en)
    );

    always_comb begin
        unit_res = Arith_OUT;
        case (sel)
            ARITH:   unit_res = Arith_OUT;
            LOGIC:   unit_res = Logic_OUT;
            CMP:     unit_res = CMP_OUT;
            SHIFT:   unit_res = Shift_OUT;
            default: unit_res = Arith_OUT;
        endcase
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        a_nxt     = A;
        b_nxt     = B;
        func_nxt  = ALU_FUNC;
        en_nxt    = '0;
        cnt_nxt   = cnt;
        valid_nxt = res_valid;
        data_nxt  = res_data;
        err_nxt   = res_err;
        case (state)
            IDLE: begin
                if (accept) begin
                    a_nxt     = cmd_A;
                    b_nxt     = cmd_B;
                    func_nxt  = cmd_func[1:0];
                    sel_nxt   = unit_sel_t'(cmd_func[3:2]);
                    en_nxt    = dec_en;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt_inc;
                // A stray flag from another unit wins over the expected one.
                if ((flags & ~sel_mask) != '0) begin
                    data_nxt  = '0;
                    err_nxt   = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = RESP;
                end else if ((flags & sel_mask) != '0) begin
                    data_nxt  = unit_res;
                    err_nxt   = 1'b0;
                    valid_nxt = 1'b1;
                    state_nxt = RESP;
                end else if (cnt_inc == CNT_MAX) begin
                    data_nxt  = '0;
                    err_nxt   = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            sel       <= ARITH;
            A         <= '0;
            B         <= '0;
            ALU_FUNC  <= '0;
            en_q      <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            A         <= a_nxt;
            B         <= b_nxt;
            ALU_FUNC  <= func_nxt;
            en_q      <= en_nxt;
            cnt       <= cnt_nxt;
            res_valid <= valid_nxt;
            res_data  <= data_nxt;
            res_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: registered unit models, response/issue scoreboards, vector table plus corner sequences.
module tb_alu_cmd_sequencer;

    localparam int TO       = 8;
    localparam int M_NORMAL = 0;
    localparam int M_SILENT = 1;
    localparam int M_WRONG  = 2;

    logic        CLK, RST;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_A, cmd_B;
    logic [3:0]  cmd_func;
    logic [15:0] A, B;
    logic [1:0]  ALU_FUNC;
    logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
    logic [15:0] Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT;
    logic        Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
    logic        res_valid, res_ready, res_err;
    logic [15:0] res_data;
    logic [3:0]  en_vec;

    typedef struct packed {
        logic [3:0]  func;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] data;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } resp_t;

    typedef struct packed {
        logic [1:0] sel;
        logic [1:0] op;
    } iss_t;

    resp_t exp_q[$];
    iss_t  iss_q[$];
    vec_t  tbl[9];
    int    checks = 0;
    int    errors = 0;
    int    pulses = 0;
    int    mode;

    assign en_vec = {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};

    alu_cmd_sequencer #(.IN_DATA_WIDTH(16), .OUT_DATA_WIDTH(16), .TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_func(cmd_func),
        .A(A), .B(B), .ALU_FUNC(ALU_FUNC),
        .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
        .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
        .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
        .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] unit_model(input logic [1:0] sel, input logic [1:0] op,
                                               input logic [15:0] a, input logic [15:0] b);
        case (sel)
            2'b00: case (op)
                2'b00: return a + b;
                2'b01: return a - b;
                2'b10: return a + 16'd1;
                default: return a - 16'd1;
            endcase
            2'b01: case (op)
                2'b00: return a & b;
                2'b01: return a | b;
                2'b10: return a ^ b;
                default: return ~(a & b);
            endcase
            2'b10: case (op)
                2'b00: return (a == b) ? 16'd1 : 16'd0;
                2'b01: return (a > b) ? 16'd1 : 16'd0;
                2'b10: return (a < b) ? 16'd1 : 16'd0;
                default: return 16'd0;
            endcase
            default: case (op)
                2'b00: return a >> 1;
                2'b01: return a << 1;
                2'b10: return a >> 4;
                default: return a << 4;
            endcase
        endcase
    endfunction

    // Registered execution units: flag is a one-cycle pulse the cycle after the enable.
    always @(posedge CLK) begin
        Arith_Flag <= 1'b0;
        Logic_Flag <= 1'b0;
        CMP_Flag   <= 1'b0;
        Shift_Flag <= 1'b0;
        if (!RST) begin
            Arith_OUT <= '0;
            Logic_OUT <= '0;
            CMP_OUT   <= '0;
            Shift_OUT <= '0;
        end else if (mode == M_NORMAL) begin
            if (Arith_Enable) begin Arith_Flag <= 1'b1; Arith_OUT <= unit_model(2'b00, ALU_FUNC, A, B); end
            if (Logic_Enable) begin Logic_Flag <= 1'b1; Logic_OUT <= unit_model(2'b01, ALU_FUNC, A, B); end
            if (CMP_Enable)   begin CMP_Flag   <= 1'b1; CMP_OUT   <= unit_model(2'b10, ALU_FUNC, A, B); end
            if (Shift_Enable) begin Shift_Flag <= 1'b1; Shift_OUT <= unit_model(2'b11, ALU_FUNC, A, B); end
        end else if (mode == M_WRONG && (|en_vec)) begin
            Logic_Flag <= 1'b1;
            Logic_OUT  <= 16'hBEEF;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin : resp_mon
        resp_t e;
        forever begin
            @(negedge CLK);
            if (RST === 1'b1 && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got data=%h err=%b, expected no response", res_data, res_err);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", 32'(res_data), 32'(e.data));
                    check("res_err", 32'(res_err), 32'(e.err));
                end
            end
        end
    end

    initial begin : issue_mon
        iss_t       it;
        logic [3:0] prev_en;
        prev_en = '0;
        forever begin
            @(negedge CLK);
            if (RST === 1'b1 && en_vec != 4'b0000) begin
                pulses++;
                check("en_width", 32'(prev_en), 32'(0));
                if (iss_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_unexpected: got enable=%b, expected none", en_vec);
                end else begin
                    it = iss_q.pop_front();
                    check("en_onehot", 32'(en_vec), 32'(1) << it.sel);
                    check("alu_func", 32'(ALU_FUNC), 32'(it.op));
                end
            end
            prev_en = en_vec;
        end
    end

    task automatic align();
        @(posedge CLK);
        #1;
    endtask

    // Returns one time unit after the accepting edge with cmd_valid still high.
    task automatic send(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_data, input logic exp_err);
        int    n;
        resp_t r;
        iss_t  it;
        cmd_valid = 1'b1;
        cmd_func  = f;
        cmd_A     = a;
        cmd_B     = b;
        n = 0;
        while (n < 50) begin
            @(negedge CLK);
            if (cmd_ready) break;
            n++;
        end
        check("cmd_accept", 32'(cmd_ready), 32'(1));
        it.sel = f[3:2];
        it.op  = f[1:0];
        iss_q.push_back(it);
        r.data = exp_data;
        r.err  = exp_err;
        exp_q.push_back(r);
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!res_valid && lat < 40);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || res_valid) && n < 60) begin
            @(negedge CLK);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int lat;
        int p0;

        tbl[0] = '{4'b0000, 16'h0005, 16'h0003, 16'h0008, 1'b0};
        tbl[1] = '{4'b0001, 16'h0005, 16'h0007, 16'hFFFE, 1'b0};
        tbl[2] = '{4'b0011, 16'h1000, 16'h0000, 16'h0FFF, 1'b0};
        tbl[3] = '{4'b0100, 16'hFF0F, 16'h0F0F, 16'h0F0F, 1'b0};
        tbl[4] = '{4'b0111, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b0};
        tbl[5] = '{4'b1001, 16'h0009, 16'h0004, 16'h0001, 1'b0};
        tbl[6] = '{4'b1010, 16'h0009, 16'h0004, 16'h0000, 1'b0};
        tbl[7] = '{4'b1110, 16'h8421, 16'h0000, 16'h0842, 1'b0};
        tbl[8] = '{4'b1111, 16'h8421, 16'h0000, 16'h4210, 1'b0};

        RST       = 1'b0;
        cmd_valid = 1'b0;
        cmd_func  = '0;
        cmd_A     = '0;
        cmd_B     = '0;
        res_ready = 1'b1;
        mode      = M_NORMAL;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;

        @(negedge CLK);
        check("rst_res_valid", 32'(res_valid), 32'(0));
        check("rst_res_data", 32'(res_data), 32'(0));
        check("rst_res_err", 32'(res_err), 32'(0));
        check("rst_enables", 32'(en_vec), 32'(0));
        check("rst_cmd_ready", 32'(cmd_ready), 32'(1));

        align();
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].func, tbl[i].a, tbl[i].b, tbl[i].data, tbl[i].err);
            cmd_valid = 1'b0;
            wait_valid(lat);
            check("tbl_latency", 32'(lat), 32'(3));
            drain();
            align();
        end

        send(4'b1101, 16'h0003, 16'h0000, 16'h0006, 1'b0);
        cmd_valid = 1'b0;
        @(negedge CLK);
        check("shift_en_t1", 32'(en_vec), 32'(4'b1000));
        @(negedge CLK);
        check("shift_en_t2", 32'(en_vec), 32'(0));
        check("shift_valid_t2", 32'(res_valid), 32'(0));
        @(negedge CLK);
        check("shift_valid_t3", 32'(res_valid), 32'(1));
        check("shift_data", 32'(res_data), 32'(16'h0006));
        check("shift_err", 32'(res_err), 32'(0));
        drain();

        align();
        res_ready = 1'b0;
        send(4'b0110, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0);
        cmd_func = 4'b0001;
        cmd_A    = 16'hAAAA;
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'(3));
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check("bp_valid", 32'(res_valid), 32'(1));
            check("bp_data", 32'(res_data), 32'(16'hFF00));
            check("bp_cmd_ready", 32'(cmd_ready), 32'(0));
        end
        align();
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("bp_release_valid", 32'(res_valid), 32'(0));
        check("bp_release_ready", 32'(cmd_ready), 32'(1));
        drain();

        align();
        mode = M_SILENT;
        send(4'b0000, 16'h0001, 16'h0002, 16'h0000, 1'b1);
        cmd_valid = 1'b0;
        wait_valid(lat);
        check("to_latency", 32'(lat), 32'(2 + TO));
        check("to_err", 32'(res_err), 32'(1));
        check("to_data", 32'(res_data), 32'(0));
        drain();
        mode = M_NORMAL;

        align();
        mode = M_WRONG;
        send(4'b1000, 16'h0005, 16'h0005, 16'h0000, 1'b1);
        cmd_valid = 1'b0;
        wait_valid(lat);
        check("wf_latency", 32'(lat), 32'(3));
        check("wf_err", 32'(res_err), 32'(1));
        drain();
        mode = M_NORMAL;

        align();
        p0 = pulses;
        send(4'b0010, 16'h7FFF, 16'h0000, 16'h8000, 1'b0);
        send(4'b0101, 16'h1200, 16'h0034, 16'h1234, 1'b0);
        send(4'b1000, 16'h0055, 16'h0055, 16'h0001, 1'b0);
        send(4'b1100, 16'h0002, 16'h0000, 16'h0001, 1'b0);
        cmd_valid = 1'b0;
        drain();
        check("b2b_pulses", 32'(pulses - p0), 32'(4));
        check("b2b_issue_left", 32'(iss_q.size()), 32'(0));

        align();
        mode = M_SILENT;
        send(4'b0001, 16'h1234, 16'h0001, 16'h0000, 1'b1);
        cmd_valid = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        exp_q.delete();
        @(negedge CLK);
        check("mid_rst_A", 32'(A), 32'(0));
        check("mid_rst_B", 32'(B), 32'(0));
        check("mid_rst_func", 32'(ALU_FUNC), 32'(0));
        check("mid_rst_en", 32'(en_vec), 32'(0));
        check("mid_rst_valid", 32'(res_valid), 32'(0));
        check("mid_rst_data", 32'(res_data), 32'(0));
        check("mid_rst_err", 32'(res_err), 32'(0));
        check("mid_rst_ready", 32'(cmd_ready), 32'(1));
        mode = M_NORMAL;
        repeat (12) @(negedge CLK);
        check("mid_rst_no_resp", 32'(res_valid), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
